// File: rtl/mem_pkg.sv
// Shared request/response types and FSM states for the cache and its backing store.
// Latency: none (types only).
// Backpressure: a requester holds Valid and its fields stable until it sees Ready.
package mem_pkg;

  localparam int BLOCK_SIZE  = 32;
  localparam int OFFSET_BITS = 2;

  typedef struct packed {
    logic                  Valid;
    logic                  Write;
    logic [31:0]           Addr;
    logic [BLOCK_SIZE-1:0] Wdata;
    logic [BLOCK_SIZE-1:0] Mask;
  } mem_input_t;

  typedef struct packed {
    logic [BLOCK_SIZE-1:0] Rdata;
    logic                  Ready;
  } mem_output_t;

  typedef enum logic [1:0] {
    IDLE,
    COMP_TAG,
    WRITE_BACK,
    ALLOCATE
  } cache_state_t;

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: each node bit points toward the colder half.
// Latency: victim is combinational from state; an access updates state next edge.
// Backpressure: none; every one-hot access is absorbed in the cycle it arrives.
module plru_tree #(
  parameter int  WAYS = 2,
  localparam int WB   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [WAYS-1:0] acc_i,
  output logic [WB-1:0]   victim_o
);

  if (WAYS == 1) begin : g_single
    logic unused_acc;
    assign unused_acc = ^{clk_i, rst_ni, acc_i};
    assign victim_o   = '0;
  end else begin : g_tree
    // Heap layout: node 1 is the root, children of n are 2n and 2n+1; bit 0 is spare.
    logic [WAYS-1:0] bits_q;
    logic [WAYS-1:0] bits_d;
    logic [WB-1:0]   acc_idx;

    // Encode the one-hot access into a way number.
    always_comb begin
      acc_idx = '0;
      for (int w = 0; w < WAYS; w++)
        if (acc_i[w]) acc_idx = acc_idx | WB'(w);
    end

    // Walk from the root following the node bits to reach the coldest leaf.
    always_comb begin
      logic [WB:0] node;
      node = (WB+1)'(1);
      for (int l = 0; l < WB; l++)
        node = {node[WB-1:0], bits_q[node[WB-1:0]]};
      victim_o = node[WB-1:0];
    end

    // Point every node on the accessed path away from the accessed way.
    always_comb begin
      logic [WB:0]   node;
      logic [WB-1:0] way;
      bits_d = bits_q;
      node   = (WB+1)'(1);
      way    = acc_idx;
      for (int l = 0; l < WB; l++) begin
        bits_d[node[WB-1:0]] = ~way[WB-1];
        node = {node[WB-1:0], way[WB-1]};
        way  = way << 1;
      end
    end

    // Commit the new recency order whenever a way is touched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)      bits_q <= '0;
      else if (|acc_i)  bits_q <= bits_d;
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// Set-associative write-back cache, one word per line, pLRU replacement.
// Latency: hit answers 2 cycles after Valid; a miss adds write-back/fill memory round trips.
// Backpressure: requester holds cache_i until Ready; memory side waits on from_mem_i.Ready.
module assoc_cache
  import mem_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  mem_input_t  cache_i,
  input  mem_output_t from_mem_i,
  output mem_input_t  to_mem_o,
  output mem_output_t cache_o,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
);

  localparam int INDEX_BITS = $clog2(SETS);
  localparam int TAG_BITS   = 32 - INDEX_BITS - OFFSET_BITS;
  localparam int WB         = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef logic [TAG_BITS-1:0]   tag_t;
  typedef logic [INDEX_BITS-1:0] idx_t;
  typedef logic [WB-1:0]         way_t;

  tag_t                  tag_q    [SETS][WAYS];
  logic [BLOCK_SIZE-1:0] data_q   [SETS][WAYS];
  logic [WAYS-1:0]       valid_q  [SETS];
  logic [WAYS-1:0]       dirty_q  [SETS];
  way_t                  plru_vic [SETS];

  cache_state_t state_q;
  mem_input_t   req_q;
  logic         filled_q;   // the current COMP_TAG pass follows a fill
  way_t         vic_q;

  idx_t                  req_idx;
  tag_t                  req_tag;
  logic [WAYS-1:0]       hit_vec;
  logic                  hit;
  way_t                  hit_way;
  way_t                  vic_way;
  logic [BLOCK_SIZE-1:0] hit_data;
  logic [BLOCK_SIZE-1:0] merged_data;
  mem_input_t            wb_req;
  mem_input_t            alloc_req;
  logic                  unused_req;

  assign req_idx     = req_q.Addr[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
  assign req_tag     = req_q.Addr[31:INDEX_BITS+OFFSET_BITS];
  assign hit         = |hit_vec;
  assign hit_data    = data_q[req_idx][hit_way];
  assign merged_data = (hit_data & ~req_q.Mask) | (req_q.Wdata & req_q.Mask);
  assign unused_req  = ^{req_q.Valid, req_q.Addr[OFFSET_BITS-1:0]};

  // Tag compare across the indexed set; victim is the lowest invalid way, else pLRU.
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    vic_way = plru_vic[req_idx];
    for (int w = WAYS-1; w >= 0; w--) begin
      hit_vec[w] = valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag);
      if (hit_vec[w])           hit_way = way_t'(w);
      if (!valid_q[req_idx][w]) vic_way = way_t'(w);
    end
  end

  // Memory requests for evicting the victim and for fetching the requested line.
  always_comb begin
    wb_req          = '0;
    wb_req.Valid    = 1'b1;
    wb_req.Write    = 1'b1;
    wb_req.Addr     = {tag_q[req_idx][vic_way], req_idx, OFFSET_BITS'(0)};
    wb_req.Wdata    = data_q[req_idx][vic_way];
    wb_req.Mask     = '1;
    alloc_req       = '0;
    alloc_req.Valid = 1'b1;
    alloc_req.Addr  = {req_tag, req_idx, OFFSET_BITS'(0)};
    alloc_req.Mask  = '1;
  end

  for (genvar s = 0; s < SETS; s++) begin : g_plru
    logic [WAYS-1:0] acc;
    // Every hit in COMP_TAG (including the one after a fill) refreshes recency.
    assign acc = (state_q == COMP_TAG && req_idx == idx_t'(s)) ? hit_vec : '0;
    plru_tree #(.WAYS(WAYS)) u_plru (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .acc_i    (acc),
      .victim_o (plru_vic[s])
    );
  end

  // Tag/data storage: loaded by a fill, merged by a write hit; deliberately unreset.
  always_ff @(posedge clk_i) begin
    if (state_q == ALLOCATE && from_mem_i.Ready) begin
      tag_q[req_idx][vic_q]  <= req_tag;
      data_q[req_idx][vic_q] <= from_mem_i.Rdata;
    end else if (state_q == COMP_TAG && hit && req_q.Write) begin
      data_q[req_idx][hit_way] <= merged_data;
    end
  end

  // Request FSM with valid/dirty bookkeeping, counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      req_q      <= '0;
      filled_q   <= 1'b0;
      vic_q      <= '0;
      to_mem_o   <= '0;
      cache_o    <= '0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      cache_o <= '0;
      case (state_q)
        IDLE: begin
          // Skip the Ready cycle: the requester still shows the request it just completed.
          if (cache_i.Valid && !cache_o.Ready) begin
            req_q   <= cache_i;
            state_q <= COMP_TAG;
          end
        end
        COMP_TAG: begin
          if (hit) begin
            cache_o.Ready <= 1'b1;
            if (req_q.Write) dirty_q[req_idx][hit_way] <= 1'b1;
            else             cache_o.Rdata <= hit_data & req_q.Mask;
            if (!filled_q && hit_cnt_o != '1) hit_cnt_o <= hit_cnt_o + 32'd1;
            filled_q <= 1'b0;
            state_q  <= IDLE;
          end else begin
            vic_q <= vic_way;
            if (!filled_q && miss_cnt_o != '1) miss_cnt_o <= miss_cnt_o + 32'd1;
            if (valid_q[req_idx][vic_way] && dirty_q[req_idx][vic_way]) begin
              to_mem_o <= wb_req;
              state_q  <= WRITE_BACK;
            end else begin
              to_mem_o <= alloc_req;
              state_q  <= ALLOCATE;
            end
          end
        end
        WRITE_BACK: begin
          if (from_mem_i.Ready) begin
            to_mem_o <= alloc_req;
            state_q  <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (from_mem_i.Ready) begin
            valid_q[req_idx][vic_q] <= 1'b1;
            dirty_q[req_idx][vic_q] <= 1'b0;
            filled_q <= 1'b1;
            to_mem_o <= '0;
            state_q  <= COMP_TAG;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Randomised and directed checks of assoc_cache against a line-level LRU model.
// Latency: hit responses must arrive exactly 2 cycles after Valid.
// Backpressure: memory responder inserts 0..2 idle cycles before each Ready.
module tb_assoc_cache;
  import mem_pkg::*;

  localparam int WAYS = 2;
  localparam int SETS = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  mem_input_t  cache_i;
  mem_output_t from_mem_i;
  mem_input_t  to_mem_o;
  mem_output_t cache_o;
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;

  always #5 clk_i = ~clk_i;

  assoc_cache #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .cache_i    (cache_i),
    .from_mem_i (from_mem_i),
    .to_mem_o   (to_mem_o),
    .cache_o    (cache_o),
    .hit_cnt_o  (hit_cnt_o),
    .miss_cnt_o (miss_cnt_o)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] mask;
  } txn_t;

  txn_t got_q[$];
  txn_t exp_q[$];

  // ---------------- backing memory (environment) ----------------
  logic [31:0] env_mem [bit [31:0]];
  bit          mem_hold = 1'b0;
  int          mem_wait = 0;

  function automatic logic [31:0] mem_init(bit [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] env_read(bit [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : mem_init(a);
  endfunction

  initial begin
    from_mem_i = '0;
    forever begin
      @(posedge clk_i); #1;
      from_mem_i = '0;
      if (to_mem_o.Valid && !mem_hold && rst_ni) begin
        if (mem_wait > 0) mem_wait--;
        else begin
          got_q.push_back('{to_mem_o.Write, to_mem_o.Addr, to_mem_o.Wdata, to_mem_o.Mask});
          if (to_mem_o.Write) env_mem[to_mem_o.Addr] = to_mem_o.Wdata;
          else from_mem_i.Rdata = env_read(to_mem_o.Addr);
          from_mem_i.Ready = 1'b1;
          mem_wait = $urandom_range(0, 2);
        end
      end
    end
  end

  // ---------------- reference model: lines, true LRU per set ----------------
  bit          m_valid [SETS][WAYS];
  bit          m_dirty [SETS][WAYS];
  logic [31:0] m_line  [SETS][WAYS];
  logic [31:0] m_data  [SETS][WAYS];
  int          m_used  [SETS][WAYS];
  int          m_clock = 0;
  int          m_hits = 0;
  int          m_misses = 0;
  logic [31:0] m_mem [bit [31:0]];

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_used[s][w]  = 0;
      end
    m_hits = 0;
    m_misses = 0;
  endfunction

  function automatic bit model_access(bit wr, logic [31:0] addr, logic [31:0] wdata,
                                      logic [31:0] mask, output logic [31:0] rdata);
    logic [31:0] line;
    int          s_i;
    int          way;
    bit          hit;
    line = addr & ~32'h3;
    s_i  = int'((addr >> 2) % SETS);
    way  = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s_i][w] && m_line[s_i][w] == line) way = w;
    hit = (way >= 0);
    if (hit) m_hits++;
    else begin
      m_misses++;
      for (int w = WAYS-1; w >= 0; w--) if (!m_valid[s_i][w]) way = w;
      if (way < 0) begin
        way = 0;
        for (int w = 1; w < WAYS; w++) if (m_used[s_i][w] < m_used[s_i][way]) way = w;
        if (m_dirty[s_i][way]) begin
          exp_q.push_back('{1'b1, m_line[s_i][way], m_data[s_i][way], 32'hFFFF_FFFF});
          m_mem[m_line[s_i][way]] = m_data[s_i][way];
        end
      end
      exp_q.push_back('{1'b0, line, 32'h0, 32'hFFFF_FFFF});
      m_data[s_i][way]  = m_mem.exists(line) ? m_mem[line] : mem_init(line);
      m_line[s_i][way]  = line;
      m_valid[s_i][way] = 1'b1;
      m_dirty[s_i][way] = 1'b0;
    end
    m_clock++;
    m_used[s_i][way] = m_clock;
    if (wr) begin
      m_data[s_i][way]  = (m_data[s_i][way] & ~mask) | (wdata & mask);
      m_dirty[s_i][way] = 1'b1;
      rdata = '0;
    end else rdata = m_data[s_i][way] & mask;
    return hit;
  endfunction

  function automatic bit log_equal();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (got_q[i])
      if (got_q[i].wr != exp_q[i].wr || got_q[i].addr !== exp_q[i].addr ||
          got_q[i].data !== exp_q[i].data || got_q[i].mask !== exp_q[i].mask) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- stimulus ----------------
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] mask, output logic [31:0] rdata,
                        output int lat, output bit ok);
    got_q.delete();
    @(posedge clk_i); #1;
    cache_i = '{Valid: 1'b1, Write: wr, Addr: addr, Wdata: wdata, Mask: mask};
    lat = 0; ok = 1'b0; rdata = '0;
    while (lat < 100 && !ok) begin
      @(posedge clk_i); #1;
      lat++;
      if (cache_o.Ready) begin
        ok = 1'b1;
        rdata = cache_o.Rdata;
      end
    end
    cache_i = '0;
  endtask

  task automatic test_reset();
    cache_i = '0;
    rst_ni  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    n_vec++; if (to_mem_o.Valid !== 1'b0 || cache_o.Ready !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs: mem_valid=%b ready=%b want 0/0", to_mem_o.Valid, cache_o.Ready);
    end
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    model_reset();
    n_vec++; if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
      n_err++; $display("FAIL reset_counters: hit=%0d miss=%0d want 0/0", hit_cnt_o, miss_cnt_o);
    end
    n_vec++; if (to_mem_o !== '0 || cache_o !== '0) begin
      n_err++; $display("FAIL reset_zero_fields: to_mem=%h cache=%h want all 0", to_mem_o, cache_o);
    end
  endtask

  task automatic test_cold_read();
    logic [31:0] rd, erd;
    int lat; bit ok, eh;
    exp_q.delete();
    eh = model_access(1'b0, 32'h40, 32'h0, 32'hFFFF_FFFF, erd);
    do_req(1'b0, 32'h40, 32'h0, 32'hFFFF_FFFF, rd, lat, ok);
    n_vec++; if (!ok || rd !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL cold_read_data: ok=%b got %h want deadbeef", ok, rd);
    end
    n_vec++; if (got_q.size() != 1 || got_q[0].wr || got_q[0].addr !== 32'h40) begin
      n_err++; $display("FAIL cold_read_alloc: %0d txns got, want one read at 0x40", got_q.size());
    end
    n_vec++; if (miss_cnt_o !== 32'd1 || hit_cnt_o !== 32'd0) begin
      n_err++; $display("FAIL cold_read_cnt: miss=%0d hit=%0d want 1/0", miss_cnt_o, hit_cnt_o);
    end
    exp_q.delete();
    eh = model_access(1'b0, 32'h40, 32'h0, 32'hFFFF_FFFF, erd);
    do_req(1'b0, 32'h40, 32'h0, 32'hFFFF_FFFF, rd, lat, ok);
    n_vec++; if (!ok || lat != 2) begin
      n_err++; $display("FAIL reread_latency: got %0d cycles want 2", lat);
    end
    n_vec++; if (rd !== erd || got_q.size() != 0 || hit_cnt_o !== 32'd1) begin
      n_err++; $display("FAIL reread_hit: data %h want %h, txns %0d want 0, hit %0d want 1",
                        rd, erd, got_q.size(), hit_cnt_o);
    end
  endtask

  task automatic test_write_hit();
    logic [31:0] rd, erd;
    int lat; bit ok, eh;
    exp_q.delete();
    eh = model_access(1'b1, 32'h40, 32'h0000_00FF, 32'h0000_00FF, erd);
    do_req(1'b1, 32'h40, 32'h0000_00FF, 32'h0000_00FF, rd, lat, ok);
    n_vec++; if (!ok || lat != 2 || got_q.size() != 0) begin
      n_err++; $display("FAIL write_hit: ok=%b lat=%0d txns=%0d want 1/2/0", ok, lat, got_q.size());
    end
    eh = model_access(1'b0, 32'h40, 32'h0, 32'hFFFF_FFFF, erd);
    do_req(1'b0, 32'h40, 32'h0, 32'hFFFF_FFFF, rd, lat, ok);
    n_vec++; if (rd !== 32'hDEADBEFF || got_q.size() != 0) begin
      n_err++; $display("FAIL write_merge: got %h want deadbeff, txns %0d want 0", rd, got_q.size());
    end
  endtask

  task automatic test_eviction();
    logic [31:0] seq [5];
    logic [31:0] rd, erd;
    int lat; bit ok, eh;
    seq = '{32'h40, 32'h80, 32'h40, 32'hC0, 32'h40};
    foreach (seq[i]) begin
      exp_q.delete();
      eh = model_access(1'b0, seq[i], 32'h0, 32'hFFFF_FFFF, erd);
      do_req(1'b0, seq[i], 32'h0, 32'hFFFF_FFFF, rd, lat, ok);
      n_vec++; if (!ok || rd !== erd || !log_equal()) begin
        n_err++; $display("FAIL evict_step%0d: addr %h data %h want %h, txns %0d want %0d",
                          i, seq[i], rd, erd, got_q.size(), exp_q.size());
      end
    end
    // 0xC0 displaced 0x80, so the final 0x40 must be a plain hit.
    n_vec++; if (lat != 2 || got_q.size() != 0) begin
      n_err++; $display("FAIL evict_keeps_0x40: lat %0d want 2, txns %0d want 0", lat, got_q.size());
    end
    n_vec++; if (hit_cnt_o !== 32'(m_hits) || miss_cnt_o !== 32'(m_misses)) begin
      n_err++; $display("FAIL evict_cnt: hit %0d want %0d, miss %0d want %0d",
                        hit_cnt_o, m_hits, miss_cnt_o, m_misses);
    end
  endtask

  task automatic test_writeback();
    logic [31:0] rd, erd;
    int lat; bit ok, eh;
    exp_q.delete();
    eh = model_access(1'b1, 32'h40, 32'h1111_0000, 32'hFFFF_0000, erd);
    do_req(1'b1, 32'h40, 32'h1111_0000, 32'hFFFF_0000, rd, lat, ok);
    exp_q.delete();
    eh = model_access(1'b0, 32'h80, 32'h0, 32'hFFFF_FFFF, erd);
    do_req(1'b0, 32'h80, 32'h0, 32'hFFFF_FFFF, rd, lat, ok);
    exp_q.delete();
    eh = model_access(1'b0, 32'hC0, 32'h0, 32'hFFFF_FFFF, erd);
    do_req(1'b0, 32'hC0, 32'h0, 32'hFFFF_FFFF, rd, lat, ok);
    n_vec++; if (got_q.size() != 2 || !got_q[0].wr || got_q[0].addr !== 32'h40 ||
                 got_q[0].data !== 32'h1111_BEFF || got_q[1].wr || got_q[1].addr !== 32'hC0) begin
      n_err++; $display("FAIL writeback_order: %0d txns, want write 0x40=1111beff then read 0xc0",
                        got_q.size());
    end
    n_vec++; if (!log_equal() || rd !== erd) begin
      n_err++; $display("FAIL writeback_model: data %h want %h", rd, erd);
    end
  endtask

  task automatic test_reset_mid_alloc();
    logic [31:0] rd, erd;
    int lat, n; bit ok, eh, seen;
    mem_hold = 1'b1;
    @(posedge clk_i); #1;
    cache_i = '{Valid: 1'b1, Write: 1'b0, Addr: 32'h94, Wdata: 32'h0, Mask: 32'hFFFF_FFFF};
    seen = 1'b0;
    for (n = 0; n < 20 && !seen; n++) begin
      @(posedge clk_i); #1;
      if (to_mem_o.Valid && !to_mem_o.Write) seen = 1'b1;
    end
    n_vec++; if (!seen) begin
      n_err++; $display("FAIL reach_allocate: no fill request within 20 cycles");
    end
    #3 rst_ni = 1'b0;
    #1;
    n_vec++; if (to_mem_o.Valid !== 1'b0 || cache_o.Ready !== 1'b0) begin
      n_err++; $display("FAIL async_reset: mem_valid=%b ready=%b want 0/0", to_mem_o.Valid, cache_o.Ready);
    end
    cache_i  = '0;
    mem_hold = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_ni = 1'b1;
    model_reset();
    @(posedge clk_i); #1;
    n_vec++; if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
      n_err++; $display("FAIL post_reset_cnt: hit=%0d miss=%0d want 0/0", hit_cnt_o, miss_cnt_o);
    end
    exp_q.delete();
    eh = model_access(1'b0, 32'h40, 32'h0, 32'hFFFF_FFFF, erd);
    do_req(1'b0, 32'h40, 32'h0, 32'hFFFF_FFFF, rd, lat, ok);
    n_vec++; if (!ok || rd !== erd || !log_equal() || miss_cnt_o !== 32'd1) begin
      n_err++; $display("FAIL post_reset_miss: data %h want %h, txns %0d want %0d, miss %0d want 1",
                        rd, erd, got_q.size(), exp_q.size(), miss_cnt_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, addr, wdata, mask;
    int lat; bit ok, eh, wr;
    for (int i = 0; i < 200; i++) begin
      wr    = 1'($urandom_range(0, 1));
      addr  = (32'($urandom_range(1, 4)) << 6) | (32'($urandom_range(0, 3)) << 2) |
              32'($urandom_range(0, 3));
      wdata = $urandom;
      mask  = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
      exp_q.delete();
      eh = model_access(wr, addr, wdata, mask, erd);
      do_req(wr, addr, wdata, mask, rd, lat, ok);
      n_vec++; if (!ok) begin
        n_err++; $display("FAIL rand%0d_ready: no Ready within 100 cycles", i);
      end
      n_vec++; if (!wr && rd !== erd) begin
        n_err++; $display("FAIL rand%0d_data: addr %h got %h want %h", i, addr, rd, erd);
      end
      n_vec++; if (eh && lat != 2) begin
        n_err++; $display("FAIL rand%0d_hit_latency: got %0d want 2", i, lat);
      end
      n_vec++; if (!log_equal()) begin
        n_err++; $display("FAIL rand%0d_mem_traffic: %0d txns got, %0d want", i, got_q.size(), exp_q.size());
      end
      n_vec++; if (hit_cnt_o !== 32'(m_hits) || miss_cnt_o !== 32'(m_misses)) begin
        n_err++; $display("FAIL rand%0d_counters: hit %0d want %0d, miss %0d want %0d",
                          i, hit_cnt_o, m_hits, miss_cnt_o, m_misses);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cache_i = '0;
    test_reset();
    test_cold_read();
    test_write_hit();
    test_eviction();
    test_writeback();
    test_reset_mid_alloc();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/assoc_cache.md
ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 SHALL have parameter WAYS, default 2: associativity; a power of two, 1..8.
REQ-002 SHALL have parameter SETS, default 16: number of sets; a power of two, >=2; INDEX_BITS = log2(SETS).
REQ-003 SHALL have port clk_i, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port cache_i, input, mem_input_t: CPU request (Valid, Write, Addr, Wdata, Mask).
REQ-006 SHALL have port from_mem_i, input, mem_output_t: backing memory response (Rdata, Ready).
REQ-007 SHALL have port to_mem_o, output, mem_input_t: backing memory request.
REQ-008 SHALL have port cache_o, output, mem_output_t: CPU response.
REQ-009 SHALL have port hit_cnt_o, output, 32 bits: saturating count of hits.
REQ-010 SHALL have port miss_cnt_o, output, 32 bits: saturating count of misses.

Function
REQ-011 SHALL hold one BLOCK_SIZE word per line, with address fields offset Addr[1:0], index Addr[INDEX_BITS+1:2], and tag Addr[31:INDEX_BITS+2].
REQ-012 SHALL implement FSM states IDLE, COMP_TAG, WRITE_BACK and ALLOCATE.
REQ-013 SHALL, in IDLE with cache_i.Valid=1, latch cache_i into a request register and go to COMP_TAG next cycle.
REQ-014 SHALL, in COMP_TAG, declare a hit when any way of the indexed set is valid and has a matching tag; the hit way is unique.
REQ-015 SHALL, on a hit, assert cache_o.Ready for exactly one cycle and return to IDLE, giving a hit latency of 2 cycles from Valid to Ready.
REQ-016 SHALL, on a read hit, drive cache_o.Rdata = line data AND Mask.
REQ-017 SHALL, on a write hit, update the line to (data AND NOT Mask) OR (Wdata AND Mask) and set the Dirty bit.
REQ-018 SHALL, on a miss, select a victim: the lowest-index invalid way, otherwise the tree pseudo-LRU way.
REQ-019 SHALL, on a miss, go to WRITE_BACK if the victim is valid and dirty, otherwise to ALLOCATE.
REQ-020 SHALL, in WRITE_BACK, drive to_mem_o with Valid=1, Write=1, Addr={victim tag, index, 2'b00}, Wdata=victim data, Mask=all ones.
REQ-021 SHALL hold WRITE_BACK until from_mem_i.Ready=1, then go to ALLOCATE.
REQ-022 SHALL, in ALLOCATE, drive to_mem_o with Valid=1, Write=0, Addr={request tag, index, 2'b00}, Mask=all ones, Wdata=0.
REQ-023 SHALL, on from_mem_i.Ready in ALLOCATE, write the victim way with Tag, Data=Rdata, Valid=1 and Dirty=0, then return to COMP_TAG; the request therefore completes as a hit.
REQ-024 SHALL, in IDLE and COMP_TAG, drive to_mem_o.Valid=0; all to_mem_o and cache_o fields SHALL be 0 when not asserted, never X.
REQ-025 SHALL update the set's pLRU so the accessed way becomes most-recent on every hit, including the post-fill hit.
REQ-026 SHALL increment miss_cnt_o once per miss detected in COMP_TAG (not again on the post-fill re-check), and hit_cnt_o only on hits that were not preceded by a fill.
REQ-027 SHALL saturate both counters at 32'hFFFF_FFFF.
REQ-028 SHALL ignore cache_i changes while not in IDLE; the requester holds the request until Ready.

Reset
REQ-029 SHALL, while rst_ni=0, force: state IDLE; all Valid, Dirty and pLRU bits 0; counters 0; to_mem_o.Valid=0; cache_o.Ready=0 (asynchronously, mid-transaction included).
REQ-030 SHALL leave tag and data storage unreset.

Structure
REQ-031 SHALL place the cache_state_t enum in mem_pkg alongside mem_input_t, mem_output_t, BLOCK_SIZE and OFFSET_BITS; the parameter-dependent tag/line arrays stay module-local.
REQ-032 SHALL implement per-set pseudo-LRU in sub-module plru_tree (victim output, one-hot access update input).

Verification (WAYS=2, SETS=16)
REQ-033 SHALL cover: cold read of 0x40, memory returns 0xDEADBEEF -> one ALLOCATE at 0x40, Rdata=0xDEADBEEF, miss=1; re-read -> Ready 2 cycles after Valid, hit=1, no memory traffic.
REQ-034 SHALL cover: write to 0x40 with Wdata=0x000000FF, Mask=0x000000FF, then read with full mask -> 0xDEADBEFF, no memory traffic.
REQ-035 SHALL cover: read 0x40, read 0x80, read 0x40, then read 0xC0 -> 0x80's way is evicted and 0x40 still hits.
REQ-036 SHALL cover: dirty 0x40, then reads of 0x80 and 0xC0 -> WRITE_BACK to 0x40 with the dirty data precedes the ALLOCATE of 0xC0.
REQ-037 SHALL cover: rst_ni pulsed low during ALLOCATE -> to_mem_o.Valid=0 in the same cycle; after release, a read of 0x40 misses and both counters equal 0 beforehand.
